// File: rtl/pin_entry_collector.sv
// Keypad front end: gathers decimal keys into a fixed-length PIN buffer and, on a full
// enter, replays the digits to the transaction controller one per cycle.
module pin_entry_collector #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TIMER_W        = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tarjeta_recibida,
  input  logic                    tecla_stb,
  input  logic [3:0]              tecla,
  output logic                    digito_stb,
  output logic [3:0]              digito,
  output logic                    pin_listo,
  output logic [4*NUM_DIGITS-1:0] pin_capturado,
  output logic [2:0]              digitos_ingresados,
  output logic                    entrada_incompleta,
  output logic                    timeout_err,
  output logic                    busy
);

  localparam int unsigned PinW = 4 * NUM_DIGITS;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [2:0]         CountFull = 3'(NUM_DIGITS);
  localparam logic [IdxW-1:0]    LastIdx   = IdxW'(NUM_DIGITS - 1);
  localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] KeyBack   = 4'hA;
  localparam logic [3:0] KeyCancel = 4'hB;
  localparam logic [3:0] KeyEnter  = 4'hC;

  typedef enum logic [1:0] {
    StIdle,
    StCaptura,
    StEnvio,
    StEspera
  } state_e;

  state_e             state_q, state_d;
  logic [PinW-1:0]    buf_q, buf_d;
  logic [2:0]         count_q, count_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               digito_stb_q, digito_stb_d;
  logic [3:0]         digito_q, digito_d;
  logic               pin_listo_q, pin_listo_d;
  logic               incompleta_q, incompleta_d;
  logic               timeout_q, timeout_d;

  logic               key_valid;
  logic               key_digit;
  logic [IdxW-1:0]    idx_next;

  // Codes D-F are not keys at all: they neither act nor restart the timer.
  assign key_valid = tecla_stb && (tecla <= KeyEnter);
  assign key_digit = (tecla <= 4'd9);
  assign idx_next  = idx_q + IdxW'(1);

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    count_d      = count_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    digito_stb_d = 1'b0;
    digito_d     = 4'h0;
    pin_listo_d  = 1'b0;
    incompleta_d = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        buf_d   = '1;
        count_d = '0;
        timer_d = '0;
        idx_d   = '0;
        if (tarjeta_recibida) begin
          state_d = StCaptura;
        end
      end

      StCaptura: begin
        if (!tarjeta_recibida) begin
          state_d = StIdle;
          buf_d   = '1;
          count_d = '0;
        end else if (key_valid) begin
          // A key on the expiry cycle wins over the timeout.
          timer_d = '0;
          if (key_digit) begin
            if (count_q < CountFull) begin
              for (int k = 0; k < NUM_DIGITS; k++) begin
                if (k == int'(count_q)) begin
                  buf_d[4*k +: 4] = tecla;
                end
              end
              count_d = count_q + 3'd1;
            end
          end else begin
            case (tecla)
              KeyBack: begin
                if (count_q != 3'd0) begin
                  for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (k == int'(count_q) - 1) begin
                      buf_d[4*k +: 4] = 4'hF;
                    end
                  end
                  count_d = count_q - 3'd1;
                end
              end
              KeyCancel: begin
                buf_d   = '1;
                count_d = '0;
              end
              default: begin
                if (count_q == CountFull) begin
                  // First digit leaves on the enter edge so the burst starts next cycle.
                  state_d      = StEnvio;
                  idx_d        = '0;
                  digito_stb_d = 1'b1;
                  digito_d     = buf_q[3:0];
                end else begin
                  incompleta_d = 1'b1;
                end
              end
            endcase
          end
        end else if (timer_q == TimerLast) begin
          timeout_d = 1'b1;
          buf_d     = '1;
          count_d   = '0;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      StEnvio: begin
        if (!tarjeta_recibida) begin
          state_d = StIdle;
          buf_d   = '1;
          count_d = '0;
          idx_d   = '0;
        end else if (idx_q != LastIdx) begin
          idx_d        = idx_next;
          digito_stb_d = 1'b1;
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == int'(idx_next)) begin
              digito_d = buf_q[4*k +: 4];
            end
          end
        end else begin
          pin_listo_d = 1'b1;
          state_d     = StEspera;
        end
      end

      StEspera: begin
        if (!tarjeta_recibida) begin
          state_d = StIdle;
          buf_d   = '1;
          count_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      buf_q        <= '1;
      count_q      <= '0;
      timer_q      <= '0;
      idx_q        <= '0;
      digito_stb_q <= 1'b0;
      digito_q     <= 4'h0;
      pin_listo_q  <= 1'b0;
      incompleta_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      digito_stb_q <= digito_stb_d;
      digito_q     <= digito_d;
      pin_listo_q  <= pin_listo_d;
      incompleta_q <= incompleta_d;
      timeout_q    <= timeout_d;
    end
  end

  assign digito_stb         = digito_stb_q;
  assign digito             = digito_q;
  assign pin_listo          = pin_listo_q;
  assign pin_capturado      = buf_q;
  assign digitos_ingresados = count_q;
  assign entrada_incompleta = incompleta_q;
  assign timeout_err        = timeout_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: doc/pin_entry_collector.md
Name: pin_entry_collector

Overview:
- Keypad front-end stage that sits directly upstream of the cashier transaction controller.
- Collects decimal key presses into a fixed-length PIN buffer and supports backspace, cancel and enter keys, plus an inactivity timeout.
- On a valid enter, replays the buffered digits to the controller as a burst of `digito_stb`/`digito` strobes, one digit per cycle, first-entered digit first.

Parameters:
- NUM_DIGITS, 4: PIN length in digits; the downstream controller expects 4, giving a 16-bit PIN.
- TIMEOUT_CYCLES, 1000: idle cycles in capture before the buffer is discarded.
- TIMER_W, 16: inactivity-timer width; must hold TIMEOUT_CYCLES-1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tarjeta_recibida  in  1  card present / session enable; level signal
- tecla_stb  in  1  one-cycle key-press strobe
- tecla  in  4  key code: 0-9 digit, 4'hA backspace, 4'hB cancel, 4'hC enter, 4'hD-4'hF ignored
- digito_stb  out  1  digit-valid strobe to the controller
- digito  out  4  digit value, qualified by digito_stb
- pin_listo  out  1  one-cycle pulse after the last digit of a burst
- pin_capturado  out  4*NUM_DIGITS  buffered PIN; digit k sits in bits [4k+3:4k]; an empty slot reads 4'hF
- digitos_ingresados  out  3  count of digits currently buffered
- entrada_incompleta  out  1  one-cycle pulse: enter pressed with fewer than NUM_DIGITS digits
- timeout_err  out  1  one-cycle pulse: buffer discarded by the inactivity timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: the block enters IDLE.
  - digito_stb, digito, pin_listo, entrada_incompleta, timeout_err, busy and digitos_ingresados reset to 0.
  - pin_capturado resets to all-F; the timer and send index reset to 0.
  - Reset has priority over all other inputs.
- All outputs are registered. Pulse outputs are high for exactly one cycle.
- States: IDLE, CAPTURA, ENVIO, ESPERA.
- IDLE:
  - The buffer is held at all-F and the count at 0.
  - tarjeta_recibida=1 → CAPTURA on the next cycle. Keys are ignored.
- CAPTURA, evaluated on each cycle with tecla_stb=1:
  - Digit 0-9 with count<NUM_DIGITS: the digit is stored in slot[count] and count is incremented. A digit with count=NUM_DIGITS is ignored.
  - Backspace with count>0: slot[count-1] is set to 4'hF and count is decremented. Backspace with count=0 is ignored.
  - Cancel: the buffer is set to all-F, count to 0, and the state stays CAPTURA.
  - Enter with count=NUM_DIGITS: → ENVIO, send index set to 0.
  - Enter with count<NUM_DIGITS: entrada_incompleta pulses; the buffer is unchanged.
  - Codes D-F are ignored and do not restart the timer.
- Inactivity timer:
  - Cleared on entry to CAPTURA and on every accepted key (0-9, A, B, C).
  - Increments on every other CAPTURA cycle.
  - When it reaches TIMEOUT_CYCLES-1: timeout_err pulses, the buffer is set to all-F, count to 0, the timer to 0, and the state stays CAPTURA.
  - If a key strobe and timer expiry occur in the same cycle, the key wins: it is processed, the timer restarts, and no timeout_err is raised.
- ENVIO:
  - If enter is accepted at clock edge N, digito_stb is high during cycles N+1..N+NUM_DIGITS.
  - digito carries slot[0], slot[1], … in order.
  - pin_listo pulses in cycle N+NUM_DIGITS+1, then → ESPERA.
  - Keys are ignored.
- ESPERA:
  - pin_capturado is held for the controller's compare; keys are ignored.
  - tarjeta_recibida=0 → IDLE.
- Abort: tarjeta_recibida=0 in CAPTURA or ENVIO → IDLE on the next edge.
  - digito_stb drops immediately, the buffer is cleared, and no pulse is raised.
  - A partially sent burst is not resumed.
- digitos_ingresados saturates at NUM_DIGITS and never wraps. The send index counts 0..NUM_DIGITS-1 and never wraps within a burst.

Test Plan:
- Reset, then tarjeta_recibida=1; keys 1,2,3,4,C → digito_stb high for 4 consecutive cycles with digito=1,2,3,4; pin_listo pulses on the next cycle; pin_capturado=16'h4321.
- Keys 5,6,A,7,8,9,C → pin_capturado=16'h9875; burst of 5,7,8,9; digitos_ingresados peaks at 4.
- Keys 1,2,C → entrada_incompleta pulses once, no digito_stb, digitos_ingresados=2. Then keys B,3,3,3,3,C → burst 3,3,3,3.
- TIMEOUT_CYCLES=8, keys 4,4 then no keys → timeout_err pulses 8 cycles after the last key; pin_capturado=16'hFFFF; digitos_ingresados=0. A key strobe on the expiry cycle must suppress timeout_err.
- Enter accepted, tarjeta_recibida dropped after the second digito_stb → no further digito_stb, no pin_listo, busy=0 on the next cycle. Reset asserted mid-CAPTURA → all outputs at reset values on the next cycle.
